// File: rtl/mips_pipe_pkg.sv
// Shared constants and types for the MIPS pipeline ID/EX stage.
// The ID_EX_FORWARD_EN macro (used by id_ex_stage/hazard_fwd_unit) selects forwarding vs. stall-only hazards.
package mips_pipe_pkg;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_REG_AW = 5;
  localparam int PIPE_CTRL_W = 4;

  // ADD must stay at zero so a bubble drives an all-zero aluctr.
  localparam logic [PIPE_CTRL_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [PIPE_CTRL_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [PIPE_CTRL_W-1:0] ALU_AND  = 4'd2;
  localparam logic [PIPE_CTRL_W-1:0] ALU_OR   = 4'd3;
  localparam logic [PIPE_CTRL_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [PIPE_CTRL_W-1:0] ALU_NOR  = 4'd5;
  localparam logic [PIPE_CTRL_W-1:0] ALU_SLT  = 4'd6;
  localparam logic [PIPE_CTRL_W-1:0] ALU_SLL  = 4'd7;
  localparam logic [PIPE_CTRL_W-1:0] ALU_SRL  = 4'd8;
  localparam logic [PIPE_CTRL_W-1:0] ALU_SRA  = 4'd9;
  localparam logic [PIPE_CTRL_W-1:0] ALU_LUI  = 4'd10;
  localparam logic [PIPE_CTRL_W-1:0] ALU_ANDI = 4'd11;
  localparam logic [PIPE_CTRL_W-1:0] ALU_ORI  = 4'd12;
  localparam logic [PIPE_CTRL_W-1:0] ALU_XORI = 4'd13;

  typedef enum logic [1:0] {
    FWD_RF,
    FWD_EXMEM,
    FWD_MEMWB
  } fwd_sel_t;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       alusrc;
    logic [4:0] shamt;
  } id_ex_t;

  localparam id_ex_t BUBBLE = '0;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational load-use / RAW stall and operand forwarding select generation.
// ID_EX_FORWARD_EN defined: forward from EX/MEM and MEM/WB, stall only on load-use; undefined: stall on any RAW.
module hazard_fwd_unit
  import mips_pipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_alusrc,
  input  logic              id_memwrite,
  input  logic              ex_valid,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              exmem_regwrite,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              memwb_regwrite,
  input  logic [REG_AW-1:0] memwb_rd,
  output logic              stall,
  output fwd_sel_t          fwd_a,
  output fwd_sel_t          fwd_b
);

  // rt is a real source for R-type ops and for stores (store data).
  function automatic logic id_reads(input logic [REG_AW-1:0] r, input logic [REG_AW-1:0] rs,
                                    input logic [REG_AW-1:0] rt, input logic rt_used);
    return (r != '0) && ((r == rs) || (rt_used && (r == rt)));
  endfunction

  function automatic fwd_sel_t pick_src(input logic [REG_AW-1:0] r,
                                        input logic xw, input logic [REG_AW-1:0] xrd,
                                        input logic ww, input logic [REG_AW-1:0] wrd);
    if (r != '0 && xw && xrd == r)
      return FWD_EXMEM;
    else if (r != '0 && ww && wrd == r)
      return FWD_MEMWB;
    else
      return FWD_RF;
  endfunction

  logic rt_used;
  assign rt_used = ~id_alusrc | id_memwrite;

`ifdef ID_EX_FORWARD_EN
  logic unused_nofwd;
  assign unused_nofwd = ex_regwrite;

  always_comb begin
    stall = 1'b0;
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    stall = id_valid && ex_valid && ex_memread && id_reads(ex_rd, id_rs, id_rt, rt_used);
    fwd_a = pick_src(ex_rs, exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd);
    fwd_b = pick_src(ex_rt, exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd);
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{ex_memread, ex_rs, ex_rt, memwb_regwrite, memwb_rd};

  // Without forwarding, wait until the producer has left EX/MEM; the regfile is write-first for MEM/WB.
  always_comb begin
    stall = 1'b0;
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    stall = id_valid &&
            ((ex_valid && ex_regwrite && id_reads(ex_rd, id_rs, id_rt, rt_used)) ||
             (exmem_regwrite && id_reads(exmem_rd, id_rs, id_rt, rt_used)));
  end
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand muxing; hazards come from hazard_fwd_unit.
// Optional macro ID_EX_FORWARD_EN enables EX/MEM and MEM/WB forwarding.
module id_ex_stage
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int REG_AW = PIPE_REG_AW,
  parameter int CTRL_W = PIPE_CTRL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_aluctr,
  input  logic [4:0]        id_shamt,
  input  logic              id_alusrc,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_memtoreg,
  input  logic              flush,
  input  logic              exmem_regwrite,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_regwrite,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  output logic              stall,
  output logic [DATA_W-1:0] alu_srcA,
  output logic [DATA_W-1:0] alu_srcB,
  output logic [CTRL_W-1:0] alu_aluctr,
  output logic [4:0]        alu_shamt,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_valid,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_memtoreg
);

  id_ex_t            ctrl_q;
  logic [REG_AW-1:0] rs_q, rt_q, rd_q;
  logic [DATA_W-1:0] rs_data_q, rt_data_q, imm_q;
  logic [CTRL_W-1:0] aluctr_q;
  fwd_sel_t          fwd_a, fwd_b;
  logic [DATA_W-1:0] rs_val, rt_val;

  hazard_fwd_unit #(.REG_AW(REG_AW)) u_hazard (
    .id_valid       (id_valid),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_alusrc      (id_alusrc),
    .id_memwrite    (id_memwrite),
    .ex_valid       (ctrl_q.valid),
    .ex_regwrite    (ctrl_q.regwrite),
    .ex_memread     (ctrl_q.memread),
    .ex_rs          (rs_q),
    .ex_rt          (rt_q),
    .ex_rd          (rd_q),
    .exmem_regwrite (exmem_regwrite),
    .exmem_rd       (exmem_rd),
    .memwb_regwrite (memwb_regwrite),
    .memwb_rd       (memwb_rd),
    .stall          (stall),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b)
  );

  // A bubble clears every field, including rs/rt, so it can never match a forward source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= BUBBLE;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      aluctr_q  <= CTRL_W'(ALU_ADD);
    end else if (flush || stall || !id_valid) begin
      ctrl_q    <= BUBBLE;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      aluctr_q  <= CTRL_W'(ALU_ADD);
    end else begin
      ctrl_q.valid    <= 1'b1;
      ctrl_q.regwrite <= id_regwrite;
      ctrl_q.memread  <= id_memread;
      ctrl_q.memwrite <= id_memwrite;
      ctrl_q.memtoreg <= id_memtoreg;
      ctrl_q.alusrc   <= id_alusrc;
      ctrl_q.shamt    <= id_shamt;
      rs_q            <= id_rs;
      rt_q            <= id_rt;
      rd_q            <= id_rd;
      rs_data_q       <= id_rs_data;
      rt_data_q       <= id_rt_data;
      imm_q           <= id_imm;
      aluctr_q        <= id_aluctr;
    end
  end

  always_comb begin
    rs_val = rs_data_q;
    rt_val = rt_data_q;
    case (fwd_a)
      FWD_EXMEM: rs_val = exmem_result;
      FWD_MEMWB: rs_val = memwb_data;
      default:   rs_val = rs_data_q;
    endcase
    case (fwd_b)
      FWD_EXMEM: rt_val = exmem_result;
      FWD_MEMWB: rt_val = memwb_data;
      default:   rt_val = rt_data_q;
    endcase
  end

  assign alu_srcA      = rs_val;
  assign alu_srcB      = ctrl_q.alusrc ? imm_q : rt_val;
  assign ex_store_data = rt_val;
  assign alu_aluctr    = aluctr_q;
  assign alu_shamt     = ctrl_q.shamt;
  assign ex_rd         = rd_q;
  assign ex_valid      = ctrl_q.valid;
  assign ex_regwrite   = ctrl_q.regwrite;
  assign ex_memread    = ctrl_q.memread;
  assign ex_memwrite   = ctrl_q.memwrite;
  assign ex_memtoreg   = ctrl_q.memtoreg;

endmodule
